pipe_seg_adder: RTL

- Parametrised, pipelined, segmented carry-chain adder/subtractor for the MAC datapath; the successor to the single-bit full adder cell.
- Splits a WIDTH-bit add into WIDTH/SEG register-separated segments, so wide accumulations close timing at full clock rate.
- Valid/ready handshake on both sides with full back-pressure.
- Provides carry-out, signed overflow and a per-operation subtract mode.

---
 rtl/pipe_seg_adder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pipe_seg_adder.sv
// Pipelined, segmented carry-chain adder/subtractor.
// Each stage resolves one SEG-bit slice of the sum. Operand bits that are not
// yet resolved ride forward in the stage registers alongside the resolved low
// sum bits. One global advance signal moves the whole pipeline, so bubbles keep
// their slots and a full pipe holds exactly STAGES beats.
module pipe_seg_adder #(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   // SEG_SAFE keeps the divide legal long enough for the check below to report.
   localparam int SEG_SAFE = (SEG < 1) ? 1 : SEG;
   localparam int STAGES   = WIDTH / SEG_SAFE;

   generate
      if ((SEG < 1) || ((WIDTH % SEG_SAFE) != 0)) begin : g_bad_params
         $error("pipe_seg_adder: WIDTH must be a positive multiple of SEG");
      end
   endgenerate

   logic             adv;
   logic [WIDTH-1:0] b_cond;
   logic             c0;

   // The pipeline moves when the output slot is empty or is being drained.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Subtraction is A + ~B + 1, so the mode is absorbed into B' and c0 at
   // entry and needs no further tracking per beat.
   assign b_cond = sub ? ~b : b;
   assign c0     = sub ? 1'b1 : cin;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         // Operand bits still unresolved when a beat enters this stage.
         localparam int OP_W = WIDTH - gi * SEG;

         logic [OP_W-1:0]       op_a;
         logic [OP_W-1:0]       op_b;
         logic                  c_in;
         logic                  v_in;
         logic [SEG:0]          seg_res;
         logic [(gi+1)*SEG-1:0] sum_next;
         logic                  valid_reg;
         logic [(gi+1)*SEG-1:0] sum_reg;
         logic                  carry_reg;

         if (gi == 0) begin : g_entry
            assign op_a     = a;
            assign op_b     = b_cond;
            assign c_in     = c0;
            assign v_in     = in_valid;
            assign sum_next = seg_res[SEG-1:0];
         end else begin : g_chain
            assign op_a     = g_stage[gi-1].g_fwd.a_fwd_reg;
            assign op_b     = g_stage[gi-1].g_fwd.b_fwd_reg;
            assign c_in     = g_stage[gi-1].carry_reg;
            assign v_in     = g_stage[gi-1].valid_reg;
            assign sum_next = {seg_res[SEG-1:0], g_stage[gi-1].sum_reg};
         end

         // Only the lowest unresolved slice is added here.
         assign seg_res = {1'b0, op_a[SEG-1:0]} + {1'b0, op_b[SEG-1:0]}
                        + {{SEG{1'b0}}, c_in};

         // Stage register: valid bit, resolved low sum and carry advance together.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               valid_reg <= 1'b0;
               sum_reg   <= '0;
               carry_reg <= 1'b0;
            end else if (adv) begin
               valid_reg <= v_in;
               sum_reg   <= sum_next;
               carry_reg <= seg_res[SEG];
            end
         end

         if (gi < STAGES - 1) begin : g_fwd
            logic [OP_W-SEG-1:0] a_fwd_reg;
            logic [OP_W-SEG-1:0] b_fwd_reg;

            // Skew the still-unresolved upper operand slices one stage forward.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  a_fwd_reg <= '0;
                  b_fwd_reg <= '0;
               end else if (adv) begin
                  a_fwd_reg <= op_a[OP_W-1:SEG];
                  b_fwd_reg <= op_b[OP_W-1:SEG];
               end
            end
         end else begin : g_last
            logic ovf_reg;
            logic msb_carry;

            // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
            assign msb_carry = seg_res[SEG-1] ^ op_a[SEG-1] ^ op_b[SEG-1];

            // Signed overflow is registered with the final slice.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  ovf_reg <= 1'b0;
               end else if (adv) begin
                  ovf_reg <= msb_carry ^ seg_res[SEG];
               end
            end
         end
      end
   endgenerate

   assign out_valid = g_stage[STAGES-1].valid_reg;
   assign sum       = g_stage[STAGES-1].sum_reg;
   assign cout      = g_stage[STAGES-1].carry_reg;
   assign ovf       = g_stage[STAGES-1].g_last.ovf_reg;

endmodule
